// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with valid/ready handshake.
// One output register plus a skid register keep full throughput under back-pressure.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int PC_WIDTH   = 32,
    parameter bit SHAMT_ZEXT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_imm,
    output logic [2:0]          out_fmt,
    output logic [PC_WIDTH-1:0] out_target,
    output logic [PC_WIDTH-1:0] out_pc
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]     imm;
        logic [2:0]          fmt;
        logic [PC_WIDTH-1:0] target;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    entry_t     dec;
    entry_t     out_q;
    entry_t     skid_q;
    logic       skid_valid;
    logic       accept;
    logic       drain;

    // Decode happens before the register so the output stage is a pure flop.
    always_comb begin
        opcode = in_inst[6:0];
        funct3 = in_inst[14:12];
        dec    = '0;
        dec.pc = in_pc;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'($signed(in_inst[31:20]));
            end
            OP_IMM: begin
                dec.fmt = FMT_I;
                // funct3 001/101 are the immediate shifts; shamt width follows XLEN
                if (SHAMT_ZEXT && funct3[1:0] == 2'b01)
                    dec.imm = (XLEN == 32) ? XLEN'(in_inst[24:20]) : XLEN'(in_inst[25:20]);
                else
                    dec.imm = XLEN'($signed(in_inst[31:20]));
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            OP_SYSTEM: begin
                if (funct3[2]) begin
                    dec.fmt = FMT_Z;
                    dec.imm = XLEN'(in_inst[19:15]);
                end
            end
            default: ;
        endcase
        dec.target = in_pc + PC_WIDTH'($signed(dec.imm));
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            // in_ready is low whenever the skid is full, so no accept can coincide here
            if (skid_valid) begin
                out_q      <= skid_q;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_q <= dec;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_imm    = out_q.imm;
    assign out_fmt    = out_q.fmt;
    assign out_target = out_q.target;
    assign out_pc     = out_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/SHAMT_ZEXT=1 and an XLEN=64/SHAMT_ZEXT=0 instance
// share stimulus; expected values come from constants and an arithmetic decode model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32, tgt32, pc32, tgt64, pc64;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int checks = 0;
    int passes = 0;

    imm_gen_pipe dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_target(tgt32), .out_pc(pc32)
    );

    imm_gen_pipe #(.XLEN(64), .PC_WIDTH(32), .SHAMT_ZEXT(1'b0)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_target(tgt64), .out_pc(pc64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    item_t q[$];

    // Known encodings with hand-derived immediates for both instances.
    localparam int ND = 12;
    logic [31:0] d_inst[ND] = '{32'hFFF00093, 32'hFE000EE3, 32'h001000EF, 32'h123452B7,
                                32'h800002B7, 32'h4030D093, 32'h03F09093, 32'h300FD073,
                                32'h002081B3, 32'hFE20AC23, 32'h30009073, 32'hFFFFF097};
    logic [31:0] d_e32[ND]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h12345000,
                                32'h80000000, 32'h00000003, 32'h0000001F, 32'h0000001F,
                                32'h00000000, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFF000};
    logic [63:0] d_e64[ND]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h800,
                                64'h12345000, 64'hFFFFFFFF80000000, 64'h403, 64'h3F, 64'h1F,
                                64'h0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'hFFFFFFFFFFFFF000};
    logic [2:0]  d_fmt[ND]  = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd4, 3'd1, 3'd1, 3'd6,
                                3'd0, 3'd2, 3'd0, 3'd4};

    function automatic longint sext(longint x, int n);
        if (x >= (longint'(1) << (n - 1))) return x - (longint'(1) << n);
        return x;
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] i, bit is64, bit zext);
        longint v;
        v = 0;
        case (i[6:0])
            7'h03, 7'h67: v = sext(longint'(i[31:20]), 12);
            7'h13: begin
                if (zext && (i[14:12] == 3'b001 || i[14:12] == 3'b101))
                    v = is64 ? longint'(i[25:20]) : longint'(i[24:20]);
                else
                    v = sext(longint'(i[31:20]), 12);
            end
            7'h23: v = sext(longint'({i[31:25], i[11:7]}), 12);
            7'h63: v = 2 * sext(longint'({i[31], i[7], i[30:25], i[11:8]}), 12);
            7'h6F: v = 2 * sext(longint'({i[31], i[19:12], i[20], i[30:21]}), 20);
            7'h37, 7'h17: v = 4096 * sext(longint'(i[31:12]), 20);
            7'h73: if (i[14]) v = longint'(i[19:15]);
            default: v = 0;
        endcase
        if (!is64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [2:0] ref_fmt(logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return 3'd1;
            7'h23:               return 3'd2;
            7'h63:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            7'h6F:               return 3'd5;
            7'h73:               return i[14] ? 3'd6 : 3'd0;
            default:             return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops[10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                                 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(7, 0) != 0) r[6:0] = ops[$urandom_range(9, 0)];
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (vld32 !== 1'b0) $display("FAIL rst_valid32: got %b exp 0", vld32); else passes++;
        checks++; if (rdy32 !== 1'b1) $display("FAIL rst_ready32: got %b exp 1", rdy32); else passes++;
        checks++; if (imm32 !== 32'h0) $display("FAIL rst_imm32: got %h exp 0", imm32); else passes++;
        checks++; if (fmt32 !== 3'd0) $display("FAIL rst_fmt32: got %0d exp 0", fmt32); else passes++;
        checks++; if (tgt32 !== 32'h0) $display("FAIL rst_target32: got %h exp 0", tgt32); else passes++;
        checks++; if (pc32 !== 32'h0) $display("FAIL rst_pc32: got %h exp 0", pc32); else passes++;
        checks++; if (vld64 !== 1'b0) $display("FAIL rst_valid64: got %b exp 0", vld64); else passes++;
        checks++; if (imm64 !== 64'h0) $display("FAIL rst_imm64: got %h exp 0", imm64); else passes++;
    endtask

    task automatic test_directed;
        logic [31:0] e32, t32, t64;
        logic [63:0] e64;
        out_ready = 1'b1;
        for (int i = 0; i < ND; i++) begin
            in_valid = 1'b1; in_inst = d_inst[i]; in_pc = 32'h100;
            @(negedge clk);
            e32 = d_e32[i]; e64 = d_e64[i];
            t32 = 32'h100 + e32; t64 = 32'h100 + e64[31:0];
            checks++; if (vld32 !== 1'b1) $display("FAIL dir_valid[%0d]: got %b exp 1", i, vld32); else passes++;
            checks++; if (imm32 !== e32) $display("FAIL dir_imm32[%0d]: got %h exp %h", i, imm32, e32); else passes++;
            checks++; if (fmt32 !== d_fmt[i]) $display("FAIL dir_fmt32[%0d]: got %0d exp %0d", i, fmt32, d_fmt[i]); else passes++;
            checks++; if (tgt32 !== t32) $display("FAIL dir_target32[%0d]: got %h exp %h", i, tgt32, t32); else passes++;
            checks++; if (pc32 !== 32'h100) $display("FAIL dir_pc32[%0d]: got %h exp 100", i, pc32); else passes++;
            checks++; if (imm64 !== e64) $display("FAIL dir_imm64[%0d]: got %h exp %h", i, imm64, e64); else passes++;
            checks++; if (fmt64 !== d_fmt[i]) $display("FAIL dir_fmt64[%0d]: got %0d exp %0d", i, fmt64, d_fmt[i]); else passes++;
            checks++; if (tgt64 !== t64) $display("FAIL dir_target64[%0d]: got %h exp %h", i, tgt64, t64); else passes++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (vld32 !== 1'b0) $display("FAIL dir_drained: got %b exp 0", vld32); else passes++;
    endtask

    task automatic test_backpressure;
        logic [31:0] bi[4];
        logic [63:0] r;
        for (int i = 0; i < 4; i++) bi[i] = rand_inst();
        in_valid = 1'b1; in_inst = bi[0]; in_pc = 32'h1000; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (vld32 !== 1'b1) $display("FAIL bp_valid0: got %b exp 1", vld32); else passes++;
        checks++; if (rdy32 !== 1'b1) $display("FAIL bp_ready0: got %b exp 1", rdy32); else passes++;
        in_inst = bi[1]; in_pc = 32'h1004;
        @(negedge clk);
        checks++; if (rdy32 !== 1'b0) $display("FAIL bp_ready_full: got %b exp 0", rdy32); else passes++;
        checks++; if (pc32 !== 32'h1000) $display("FAIL bp_hold1: got %h exp 1000", pc32); else passes++;
        in_inst = bi[2]; in_pc = 32'h1008;
        @(negedge clk);
        r = ref_imm(bi[0], 1'b0, 1'b1);
        checks++; if (rdy32 !== 1'b0) $display("FAIL bp_ready_stall: got %b exp 0", rdy32); else passes++;
        checks++; if (pc32 !== 32'h1000) $display("FAIL bp_hold2: got %h exp 1000", pc32); else passes++;
        checks++; if (imm32 !== r[31:0]) $display("FAIL bp_imm0: got %h exp %h", imm32, r[31:0]); else passes++;
        out_ready = 1'b1;
        @(negedge clk);
        r = ref_imm(bi[1], 1'b0, 1'b1);
        checks++; if (vld32 !== 1'b1) $display("FAIL bp_valid1: got %b exp 1", vld32); else passes++;
        checks++; if (pc32 !== 32'h1004) $display("FAIL bp_pc1: got %h exp 1004", pc32); else passes++;
        checks++; if (imm32 !== r[31:0]) $display("FAIL bp_imm1: got %h exp %h", imm32, r[31:0]); else passes++;
        checks++; if (rdy32 !== 1'b1) $display("FAIL bp_ready_free: got %b exp 1", rdy32); else passes++;
        @(negedge clk);
        r = ref_imm(bi[2], 1'b0, 1'b1);
        checks++; if (pc32 !== 32'h1008) $display("FAIL bp_pc2: got %h exp 1008", pc32); else passes++;
        checks++; if (imm32 !== r[31:0]) $display("FAIL bp_imm2: got %h exp %h", imm32, r[31:0]); else passes++;
        in_inst = bi[3]; in_pc = 32'h100C;
        @(negedge clk);
        r = ref_imm(bi[3], 1'b0, 1'b1);
        checks++; if (vld32 !== 1'b1) $display("FAIL bp_valid3: got %b exp 1", vld32); else passes++;
        checks++; if (pc32 !== 32'h100C) $display("FAIL bp_pc3: got %h exp 100c", pc32); else passes++;
        checks++; if (imm32 !== r[31:0]) $display("FAIL bp_imm3: got %h exp %h", imm32, r[31:0]); else passes++;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (vld32 !== 1'b0) $display("FAIL bp_empty: got %b exp 0", vld32); else passes++;
    endtask

    task automatic test_flush;
        in_valid = 1'b1; in_inst = rand_inst(); in_pc = 32'h2000; out_ready = 1'b0;
        @(negedge clk);
        in_inst = rand_inst(); in_pc = 32'h2004;
        @(negedge clk);
        checks++; if (rdy32 !== 1'b0) $display("FAIL fl_full: got %b exp 0", rdy32); else passes++;
        flush = 1'b1; in_inst = rand_inst(); in_pc = 32'h2008;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (vld32 !== 1'b0) $display("FAIL fl_valid32: got %b exp 0", vld32); else passes++;
        checks++; if (vld64 !== 1'b0) $display("FAIL fl_valid64: got %b exp 0", vld64); else passes++;
        checks++; if (rdy32 !== 1'b1) $display("FAIL fl_ready: got %b exp 1", rdy32); else passes++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (vld32 !== 1'b0) $display("FAIL fl_ghost[%0d]: got %b pc %h exp 0", i, vld32, pc32); else passes++;
        end
        in_valid = 1'b1; in_inst = 32'h001000EF; in_pc = 32'h200C;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (vld32 !== 1'b1) $display("FAIL fl_resume_valid: got %b exp 1", vld32); else passes++;
        checks++; if (pc32 !== 32'h200C) $display("FAIL fl_resume_pc: got %h exp 200c", pc32); else passes++;
        checks++; if (tgt32 !== 32'h280C) $display("FAIL fl_resume_target: got %h exp 280c", tgt32); else passes++;
        @(negedge clk);
    endtask

    task automatic test_reset_midstream;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h3000; out_ready = 1'b0;
        @(negedge clk);
        in_inst = 32'hFE000EE3; in_pc = 32'h3004;
        @(negedge clk);
        rst = 1'b1; in_inst = 32'h123452B7; in_pc = 32'h3008;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        checks++; if (vld32 !== 1'b0) $display("FAIL mr_valid: got %b exp 0", vld32); else passes++;
        checks++; if (rdy32 !== 1'b1) $display("FAIL mr_ready: got %b exp 1", rdy32); else passes++;
        checks++; if (imm32 !== 32'h0) $display("FAIL mr_imm32: got %h exp 0", imm32); else passes++;
        checks++; if (fmt32 !== 3'd0) $display("FAIL mr_fmt32: got %0d exp 0", fmt32); else passes++;
        checks++; if (tgt32 !== 32'h0) $display("FAIL mr_target32: got %h exp 0", tgt32); else passes++;
        checks++; if (pc32 !== 32'h0) $display("FAIL mr_pc32: got %h exp 0", pc32); else passes++;
        checks++; if (imm64 !== 64'h0) $display("FAIL mr_imm64: got %h exp 0", imm64); else passes++;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (vld32 !== 1'b0) $display("FAIL mr_ghost: got %b exp 0", vld32); else passes++;
    endtask

    task automatic test_random_stream;
        logic [63:0] r32, r64;
        logic [31:0] t32, t64;
        logic        fl, acc, drn;
        item_t       it;
        q.delete();
        for (int c = 0; c < 800; c++) begin
            checks++; if (vld32 !== (q.size() != 0)) $display("FAIL rnd_valid32 c%0d: got %b held %0d", c, vld32, q.size()); else passes++;
            checks++; if (rdy32 !== (q.size() < 2)) $display("FAIL rnd_ready32 c%0d: got %b held %0d", c, rdy32, q.size()); else passes++;
            checks++; if (vld64 !== (q.size() != 0)) $display("FAIL rnd_valid64 c%0d: got %b held %0d", c, vld64, q.size()); else passes++;
            if (q.size() != 0) begin
                r32 = ref_imm(q[0].inst, 1'b0, 1'b1);
                r64 = ref_imm(q[0].inst, 1'b1, 1'b0);
                t32 = q[0].pc + r32[31:0];
                t64 = q[0].pc + r64[31:0];
                checks++; if (imm32 !== r32[31:0]) $display("FAIL rnd_imm32 c%0d inst %h: got %h exp %h", c, q[0].inst, imm32, r32[31:0]); else passes++;
                checks++; if (fmt32 !== ref_fmt(q[0].inst)) $display("FAIL rnd_fmt32 c%0d inst %h: got %0d exp %0d", c, q[0].inst, fmt32, ref_fmt(q[0].inst)); else passes++;
                checks++; if (pc32 !== q[0].pc) $display("FAIL rnd_pc32 c%0d: got %h exp %h", c, pc32, q[0].pc); else passes++;
                checks++; if (tgt32 !== t32) $display("FAIL rnd_target32 c%0d: got %h exp %h", c, tgt32, t32); else passes++;
                checks++; if (imm64 !== r64) $display("FAIL rnd_imm64 c%0d inst %h: got %h exp %h", c, q[0].inst, imm64, r64); else passes++;
                checks++; if (tgt64 !== t64) $display("FAIL rnd_target64 c%0d: got %h exp %h", c, tgt64, t64); else passes++;
                checks++; if (pc64 !== q[0].pc) $display("FAIL rnd_pc64 c%0d: got %h exp %h", c, pc64, q[0].pc); else passes++;
            end
            fl        = ($urandom_range(49, 0) == 0);
            flush     = fl;
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            acc = in_valid && (q.size() < 2);
            drn = out_ready && (q.size() != 0);
            it.inst = in_inst; it.pc = in_pc;
            @(posedge clk);
            if (fl) q.delete();
            else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(it);
            end
            @(negedge clk);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random_stream();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
